// File: rtl/ifetch_prefetch_pkg.sv
// Shared constants, types and helpers for the instruction-fetch front end.
package ifetch_prefetch_pkg;

  // Default first fetch address after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_INC = 4;

  // What happens to a memory response in the cycle it arrives.
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_DROP,
    RESP_KEEP
  } respAction_e;

  // Queue entry holds {pc, inst}.
  function automatic int unsigned entryWidth(input int unsigned xlen);
    return 2 * xlen;
  endfunction

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned ptrWidth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifetch_prefetch_fetch_fifo.sv
// Synchronous FIFO with registered storage, flush and occupancy count.
module fetch_fifo
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             pushData,
  output logic [WIDTH-1:0]             popData,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = ptrWidth(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Status flags, qualified handshakes and head read-out.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    doPop   = pop && !empty;
    doPush  = push && (!full || doPop);
    popData = mem[rdPtr];
  end

  // Pointer and occupancy update; flush empties the FIFO like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch front end: in-order word fetch over a valid/ready
// request channel, prefetch queue towards decode, redirect flush.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_Redirect_1,
  input  logic [XLEN-1:0] i_RedirectPC_32,
  output logic            o_MemReqValid_1,
  input  logic            i_MemReqReady_1,
  output logic [XLEN-1:0] o_MemReqAddr_32,
  input  logic            i_MemRespValid_1,
  input  logic [XLEN-1:0] i_MemRespData_32,
  output logic            o_InstValid_1,
  output logic [XLEN-1:0] o_InstPC_32,
  output logic [XLEN-1:0] o_Inst_32,
  input  logic            i_InstReady_1
);

  localparam int unsigned EW  = entryWidth(XLEN);
  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] redirectTarget;
  logic            reqFire;
  logic            respFire;
  logic            instFire;
  respAction_e     respAction;

  logic [QCW-1:0]  qCount;
  logic            qFull;
  logic            qEmpty;
  logic [EW-1:0]   qHead;

  logic [XLEN-1:0] inflightPc;
  logic            inflightFull;
  logic            inflightEmpty;
  // The in-flight FIFO occupancy is the outstanding-request count.
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstandingNext;
  logic [OW-1:0]   dropCount;

  // Request issue: credit for every issued request is reserved in the queue.
  always_comb begin
    o_MemReqValid_1 = !rst && !inflightFull &&
                      ((32'(qCount) + 32'(outstanding)) < DEPTH);
    o_MemReqAddr_32 = fetchPc;
    reqFire         = o_MemReqValid_1 && i_MemReqReady_1;
    respFire        = i_MemRespValid_1;
    instFire        = !qEmpty && i_InstReady_1;
    redirectTarget  = i_RedirectPC_32 & {{(XLEN-2){1'b1}}, 2'b00};
    outstandingNext = outstanding + OW'(reqFire) - OW'(respFire);
  end

  // Response disposition: stale responses and redirect-cycle data are dropped.
  always_comb begin
    respAction = RESP_NONE;
    if (respFire) begin
      if (i_Redirect_1 || (dropCount != '0)) respAction = RESP_DROP;
      else                                   respAction = RESP_KEEP;
    end
  end

  // Fetch PC: redirect overrides the increment of a same-cycle request.
  always_ff @(posedge clk) begin
    if (rst)               fetchPc <= RESET_PC;
    else if (i_Redirect_1) fetchPc <= redirectTarget;
    else if (reqFire)      fetchPc <= fetchPc + XLEN'(PC_INC);
  end

  // Drop counter: on redirect every request still in flight after this cycle is stale.
  always_ff @(posedge clk) begin
    if (rst)                           dropCount <= '0;
    else if (i_Redirect_1)             dropCount <= outstandingNext;
    else if (respAction == RESP_DROP)  dropCount <= dropCount - 1'b1;
  end

  // Queue head presentation (registered storage, no input-to-output path).
  always_comb begin
    o_InstValid_1            = !qEmpty;
    {o_InstPC_32, o_Inst_32} = qHead;
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_instQueue (
    .clk      (clk),
    .rst      (rst),
    .push     (respAction == RESP_KEEP),
    .pop      (instFire),
    .flush    (i_Redirect_1),
    .pushData ({inflightPc, i_MemRespData_32}),
    .popData  (qHead),
    .full     (qFull),
    .empty    (qEmpty),
    .count    (qCount)
  );

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflightPc (
    .clk      (clk),
    .rst      (rst),
    .push     (reqFire),
    .pop      (respFire),
    .flush    (1'b0),
    .pushData (fetchPc),
    .popData  (inflightPc),
    .full     (inflightFull),
    .empty    (inflightEmpty),
    .count    (outstanding)
  );

  // Protocol checks: no queue overflow, no response without a request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!((respAction == RESP_KEEP) && qFull && !instFire));
      assert (!(respFire && inflightEmpty));
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed self-checking bench for ifetch_prefetch with a variable-latency
// in-order memory model returning addr ^ 0xA5A5A5A5.
module tb_ifetch_prefetch;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     DEPTH    = 4;
  localparam int unsigned     MAXO     = 2;
  localparam logic [31:0]     RESET_PC = 32'h0000_0000;
  localparam logic [31:0]     MAGIC    = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        respValid;
  logic [31:0] respData;
  logic        instValid;
  logic [31:0] instPc;
  logic [31:0] inst;
  logic        instReady;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int memLat = 1;

  logic [31:0] pendAddr[$];
  int          pendDue[$];
  logic [31:0] reqLog[$];
  int          reqCyc[$];
  logic [31:0] delPc[$];
  logic [31:0] delInst[$];
  int          delCyc[$];

  ifetch_prefetch #(
    .XLEN            (XLEN),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_Redirect_1     (redirect),
    .i_RedirectPC_32  (redirectPc),
    .o_MemReqValid_1  (reqValid),
    .i_MemReqReady_1  (reqReady),
    .o_MemReqAddr_32  (reqAddr),
    .i_MemRespValid_1 (respValid),
    .i_MemRespData_32 (respData),
    .o_InstValid_1    (instValid),
    .o_InstPC_32      (instPc),
    .o_Inst_32        (inst),
    .i_InstReady_1    (instReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory response driver: presents the oldest pending response once due.
  initial begin
    respValid = 1'b0;
    respData  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pendDue.size() > 0 && pendDue[0] <= cyc) begin
        respValid = 1'b1;
        respData  = pendAddr[0] ^ MAGIC;
      end else begin
        respValid = 1'b0;
        respData  = '0;
      end
    end
  end

  // Mid-cycle observation of handshakes that complete at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      pendAddr.delete();
      pendDue.delete();
    end else begin
      if (respValid) begin
        void'(pendAddr.pop_front());
        void'(pendDue.pop_front());
      end
      if (reqValid && reqReady) begin
        pendAddr.push_back(reqAddr);
        pendDue.push_back(cyc + memLat);
        reqLog.push_back(reqAddr);
        reqCyc.push_back(cyc);
      end
      if (instValid && instReady) begin
        delPc.push_back(instPc);
        delInst.push_back(inst);
        delCyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    reqLog.delete();
    reqCyc.delete();
    delPc.delete();
    delInst.delete();
    delCyc.delete();
  endtask

  task automatic applyReset();
    rst        = 1'b1;
    redirect   = 1'b0;
    redirectPc = '0;
    reqReady   = 1'b1;
    instReady  = 1'b1;
    memLat     = 1;
    tick(2);
    rst = 1'b0;
    clearLogs();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    redirect   = 1'b0;
    redirectPc = '0;
    reqReady   = 1'b1;
    instReady  = 1'b1;
    memLat     = 1;
    tick(2);
    checks++;
    if (reqValid !== 1'b0) begin errors++; $display("FAIL reset_reqValid: got %b expected 0", reqValid); end
    checks++;
    if (instValid !== 1'b0) begin errors++; $display("FAIL reset_instValid: got %b expected 0", instValid); end
    rst = 1'b0;
    #1;
    checks++;
    if (reqValid !== 1'b1) begin errors++; $display("FAIL first_reqValid: got %b expected 1", reqValid); end
    checks++;
    if (reqAddr !== RESET_PC) begin errors++; $display("FAIL first_reqAddr: got %h expected %h", reqAddr, RESET_PC); end
    checks++;
    if (instValid !== 1'b0) begin errors++; $display("FAIL first_instValid: got %b expected 0", instValid); end
  endtask

  task automatic test_stream();
    applyReset();
    tick(14);
    checks++;
    if (reqLog.size() < 8) begin
      errors++; $display("FAIL stream_reqCount: got %0d expected >=8", reqLog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (reqLog[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_reqAddr[%0d]: got %h expected %h", i, reqLog[i], 32'(4 * i)); end
        checks++;
        if (reqCyc[i] !== reqCyc[0] + i) begin errors++; $display("FAIL stream_reqCycle[%0d]: got %0d expected %0d", i, reqCyc[i], reqCyc[0] + i); end
      end
    end
    checks++;
    if (delPc.size() < 8) begin
      errors++; $display("FAIL stream_instCount: got %0d expected >=8", delPc.size());
    end else begin
      checks++;
      if (delCyc[0] !== reqCyc[0] + 2) begin errors++; $display("FAIL stream_firstLatency: got %0d expected %0d", delCyc[0] - reqCyc[0], 2); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (delPc[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_instPc[%0d]: got %h expected %h", i, delPc[i], 32'(4 * i)); end
        checks++;
        if (delInst[i] !== (32'(4 * i) ^ MAGIC)) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, delInst[i], 32'(4 * i) ^ MAGIC); end
        checks++;
        if (delCyc[i] !== delCyc[0] + i) begin errors++; $display("FAIL stream_instCycle[%0d]: got %0d expected %0d", i, delCyc[i], delCyc[0] + i); end
      end
    end
  endtask

  task automatic test_backpressure();
    applyReset();
    instReady = 1'b0;
    tick(10);
    checks++;
    if (reqLog.size() !== 4) begin
      errors++; $display("FAIL bp_reqCount: got %0d expected 4", reqLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (reqLog[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_reqAddr[%0d]: got %h expected %h", i, reqLog[i], 32'(4 * i)); end
      end
    end
    checks++;
    if (reqValid !== 1'b0) begin errors++; $display("FAIL bp_reqValidLow: got %b expected 0", reqValid); end
    checks++;
    if (instValid !== 1'b1) begin errors++; $display("FAIL bp_instValid: got %b expected 1", instValid); end
    checks++;
    if (instPc !== 32'h0) begin errors++; $display("FAIL bp_headPc: got %h expected %h", instPc, 32'h0); end
    instReady = 1'b1;
    tick(12);
    checks++;
    if (delPc.size() < 4) begin
      errors++; $display("FAIL bp_instCount: got %0d expected >=4", delPc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (delPc[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_instPc[%0d]: got %h expected %h", i, delPc[i], 32'(4 * i)); end
        checks++;
        if (delInst[i] !== (32'(4 * i) ^ MAGIC)) begin errors++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, delInst[i], 32'(4 * i) ^ MAGIC); end
      end
    end
    checks++;
    if (reqLog.size() < 5) begin
      errors++; $display("FAIL bp_resumeCount: got %0d expected >=5", reqLog.size());
    end else begin
      checks++;
      if (reqLog[4] !== 32'h10) begin errors++; $display("FAIL bp_resumeAddr: got %h expected %h", reqLog[4], 32'h10); end
    end
  endtask

  task automatic test_stall();
    applyReset();
    tick(2);
    reqReady = 1'b0;
    clearLogs();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (reqValid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, reqValid); end
      checks++;
      if (reqAddr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, reqAddr, 32'h8); end
      tick(1);
    end
    checks++;
    if (reqLog.size() !== 0) begin errors++; $display("FAIL stall_noFire: got %0d expected 0", reqLog.size()); end
    reqReady = 1'b1;
    tick(4);
    checks++;
    if (reqLog.size() < 2) begin
      errors++; $display("FAIL stall_releaseCount: got %0d expected >=2", reqLog.size());
    end else begin
      checks++;
      if (reqLog[0] !== 32'h8) begin errors++; $display("FAIL stall_release0: got %h expected %h", reqLog[0], 32'h8); end
      checks++;
      if (reqLog[1] !== 32'hC) begin errors++; $display("FAIL stall_release1: got %h expected %h", reqLog[1], 32'hC); end
    end
  endtask

  task automatic test_redirect();
    applyReset();
    memLat = 3;
    tick(2);
    checks++;
    if (reqLog.size() !== 2) begin errors++; $display("FAIL redir_outstanding: got %0d expected 2", reqLog.size()); end
    checks++;
    if (reqValid !== 1'b0) begin errors++; $display("FAIL redir_creditStop: got %b expected 0", reqValid); end
    redirect   = 1'b1;
    redirectPc = 32'h103;
    clearLogs();
    tick(1);
    redirect = 1'b0;
    checks++;
    if (reqAddr !== 32'h100) begin errors++; $display("FAIL redir_newAddr: got %h expected %h", reqAddr, 32'h100); end
    tick(14);
    checks++;
    if (reqLog.size() < 1) begin
      errors++; $display("FAIL redir_reqCount: got %0d expected >=1", reqLog.size());
    end else begin
      checks++;
      if (reqLog[0] !== 32'h100) begin errors++; $display("FAIL redir_firstReq: got %h expected %h", reqLog[0], 32'h100); end
    end
    checks++;
    if (delPc.size() < 3) begin
      errors++; $display("FAIL redir_instCount: got %0d expected >=3", delPc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (delPc[i] !== 32'(32'h100 + 4 * i)) begin errors++; $display("FAIL redir_instPc[%0d]: got %h expected %h", i, delPc[i], 32'(32'h100 + 4 * i)); end
        checks++;
        if (delInst[i] !== (32'(32'h100 + 4 * i) ^ MAGIC)) begin errors++; $display("FAIL redir_inst[%0d]: got %h expected %h", i, delInst[i], 32'(32'h100 + 4 * i) ^ MAGIC); end
      end
    end
  endtask

  task automatic test_redirect_same_cycle();
    applyReset();
    tick(8);
    checks++;
    if (reqValid !== 1'b1) begin errors++; $display("FAIL same_reqValid: got %b expected 1", reqValid); end
    checks++;
    if (reqAddr !== 32'h20) begin errors++; $display("FAIL same_reqAddr: got %h expected %h", reqAddr, 32'h20); end
    clearLogs();
    redirect   = 1'b1;
    redirectPc = 32'h200;
    tick(1);
    redirect = 1'b0;
    checks++;
    if (reqAddr !== 32'h200) begin errors++; $display("FAIL same_newAddr: got %h expected %h", reqAddr, 32'h200); end
    checks++;
    if (instValid !== 1'b0) begin errors++; $display("FAIL same_flushed: got %b expected 0", instValid); end
    tick(1);
    checks++;
    if (instValid !== 1'b0) begin errors++; $display("FAIL same_notYet: got %b expected 0", instValid); end
    tick(1);
    checks++;
    if (instValid !== 1'b1) begin errors++; $display("FAIL same_firstValid: got %b expected 1", instValid); end
    checks++;
    if (instPc !== 32'h200) begin errors++; $display("FAIL same_firstPc: got %h expected %h", instPc, 32'h200); end
    checks++;
    if (inst !== (32'h200 ^ MAGIC)) begin errors++; $display("FAIL same_firstInst: got %h expected %h", inst, 32'h200 ^ MAGIC); end
    tick(6);
    checks++;
    if (delPc.size() < 3) begin
      errors++; $display("FAIL same_instCount: got %0d expected >=3", delPc.size());
    end else begin
      checks++;
      if (delPc[0] !== 32'h18) begin errors++; $display("FAIL same_consumedHead: got %h expected %h", delPc[0], 32'h18); end
      checks++;
      if (delPc[1] !== 32'h200) begin errors++; $display("FAIL same_noStale: got %h expected %h", delPc[1], 32'h200); end
      checks++;
      if (delPc[2] !== 32'h204) begin errors++; $display("FAIL same_next: got %h expected %h", delPc[2], 32'h204); end
    end
    checks++;
    if (reqLog.size() < 2) begin
      errors++; $display("FAIL same_reqCount: got %0d expected >=2", reqLog.size());
    end else begin
      checks++;
      if (reqLog[0] !== 32'h20) begin errors++; $display("FAIL same_req0: got %h expected %h", reqLog[0], 32'h20); end
      checks++;
      if (reqLog[1] !== 32'h200) begin errors++; $display("FAIL same_req1: got %h expected %h", reqLog[1], 32'h200); end
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    instReady = 1'b0;
    tick(4);
    checks++;
    if (instValid !== 1'b1) begin errors++; $display("FAIL mid_preValid: got %b expected 1", instValid); end
    checks++;
    if (reqLog.size() !== 4) begin errors++; $display("FAIL mid_preReqs: got %0d expected 4", reqLog.size()); end
    rst = 1'b1;
    tick(1);
    checks++;
    if (instValid !== 1'b0) begin errors++; $display("FAIL mid_instValid: got %b expected 0", instValid); end
    checks++;
    if (reqValid !== 1'b0) begin errors++; $display("FAIL mid_reqValid: got %b expected 0", reqValid); end
    rst = 1'b0;
    clearLogs();
    #1;
    checks++;
    if (reqValid !== 1'b1) begin errors++; $display("FAIL mid_restartValid: got %b expected 1", reqValid); end
    checks++;
    if (reqAddr !== RESET_PC) begin errors++; $display("FAIL mid_restartAddr: got %h expected %h", reqAddr, RESET_PC); end
    instReady = 1'b1;
    tick(4);
    checks++;
    if (delPc.size() < 1) begin
      errors++; $display("FAIL mid_instCount: got %0d expected >=1", delPc.size());
    end else begin
      checks++;
      if (delPc[0] !== RESET_PC) begin errors++; $display("FAIL mid_firstPc: got %h expected %h", delPc[0], RESET_PC); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
